// File: rtl/video_pkg.sv
// video_pkg: shared video timing defaults, frame reader states and Wishbone constants
package video_pkg;
  localparam int HDISP_DEF = 800;
  localparam int VDISP_DEF = 480;
  localparam logic [2:0] WB_CTI_CLASSIC = 3'b000;
  localparam logic [1:0] WB_BTE_LINEAR = 2'b00;
  typedef enum logic {IDLE, REQ} frame_rd_state_t;
endpackage

// File: rtl/wshb_frame_reader.sv
// wshb_frame_reader: Wishbone master streaming a framebuffer from SDRAM into the video FIFO
module wshb_frame_reader
  import video_pkg::*;
#(
  parameter int HDISP = HDISP_DEF,
  parameter int VDISP = VDISP_DEF,
  parameter int ADDR_W = 32,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
  input  logic              sys_clk,
  input  logic              sys_rst,
  input  logic              enable,
  output logic [ADDR_W-1:0] wb_adr,
  output logic              wb_cyc,
  output logic              wb_stb,
  output logic              wb_we,
  output logic [3:0]        wb_sel,
  output logic [2:0]        wb_cti,
  output logic [1:0]        wb_bte,
  output logic [31:0]       wb_dat_ms,
  input  logic [31:0]       wb_dat_sm,
  input  logic              wb_ack,
  input  logic              wb_err,
  input  logic              wb_rty,
  output logic [31:0]       fifo_wdata,
  output logic              fifo_write,
  output logic              fifo_sof,
  input  logic              fifo_walmost_full
);
  localparam int NWORDS = HDISP * VDISP;
  localparam int IW = NWORDS > 1 ? $clog2(NWORDS) : 1;
  frame_rd_state_t state, state_nxt;
  logic [IW-1:0] idx, idx_nxt;
  logic go, done;
  assign go = enable && !fifo_walmost_full;
  assign done = state == REQ && (wb_ack || wb_err);
  assign idx_nxt = idx == IW'(NWORDS - 1) ? '0 : idx + 1'b1;
  assign wb_we = 1'b0;
  assign wb_sel = 4'hF;
  assign wb_cti = WB_CTI_CLASSIC;
  assign wb_bte = WB_BTE_LINEAR;
  assign wb_dat_ms = '0;
  // state register; cyc/stb are decoded straight from it so they stay registered
  always_ff @(posedge sys_clk)
    state <= sys_rst ? IDLE : state_nxt;
  // a terminated or idle request is (re)issued only when the FIFO has room; retry drops cyc for one cycle
  always_comb begin
    state_nxt = state;
    if (state == IDLE) state_nxt = go ? REQ : IDLE;
    else if (wb_ack || wb_err) state_nxt = go ? REQ : IDLE;
    else if (wb_rty) state_nxt = IDLE;
  end
  // bus strobes follow the request state
  always_comb begin
    wb_cyc = state == REQ;
    wb_stb = state == REQ;
  end
  // pixel counter, address and FIFO push; an error pushes zero to keep pixel alignment
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      idx <= '0;
      wb_adr <= BASE_ADDR;
      fifo_write <= 1'b0;
      fifo_sof <= 1'b0;
      fifo_wdata <= '0;
    end else begin
      fifo_write <= done;
      fifo_sof <= done && idx == '0;
      if (done) begin
        fifo_wdata <= wb_ack ? wb_dat_sm : '0;
        idx <= idx_nxt;
        wb_adr <= BASE_ADDR + (ADDR_W'(idx_nxt) << 2);
      end
    end
  end
endmodule

// File: tb/tb_wshb_frame_reader.sv
// tb_wshb_frame_reader: randomized and directed checks of the frame reader against a pixel-count model
module tb_wshb_frame_reader;
  localparam int NW = 8;
  localparam logic [31:0] BASE = 32'h0000_1000;
  logic clk = 0, rst = 1, enable = 0, ack = 0, err = 0, rty = 0, af = 0;
  logic [31:0] dat_sm = 0;
  logic [31:0] wb_adr, wb_dat_ms, fifo_wdata;
  logic wb_cyc, wb_stb, wb_we, fifo_write, fifo_sof;
  logic [3:0] wb_sel;
  logic [2:0] wb_cti;
  logic [1:0] wb_bte;
  int tests = 0, fails = 0;
  bit run = 0;
  bit m_busy = 0, m_push = 0, m_sof = 0;
  int m_pos = 0;
  logic [31:0] m_wdata = 0;

  wshb_frame_reader #(.HDISP(4), .VDISP(2), .ADDR_W(32), .BASE_ADDR(BASE)) dut (
    .sys_clk(clk), .sys_rst(rst), .enable(enable),
    .wb_adr(wb_adr), .wb_cyc(wb_cyc), .wb_stb(wb_stb), .wb_we(wb_we),
    .wb_sel(wb_sel), .wb_cti(wb_cti), .wb_bte(wb_bte), .wb_dat_ms(wb_dat_ms),
    .wb_dat_sm(dat_sm), .wb_ack(ack), .wb_err(err), .wb_rty(rty),
    .fifo_wdata(fifo_wdata), .fifo_write(fifo_write), .fifo_sof(fifo_sof),
    .fifo_walmost_full(af)
  );

  always #5 clk = ~clk;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // compare DUT outputs with the model on every falling edge
  always @(negedge clk) if (run) begin
    chk("cyc", wb_cyc, m_busy);
    chk("stb", wb_stb, m_busy);
    chk("adr", wb_adr, BASE + 32'(4 * m_pos));
    chk("write", fifo_write, m_push);
    if (m_push) begin
      chk("wdata", fifo_wdata, m_wdata);
      chk("sof", fifo_sof, m_sof);
    end
    chk("consts", {wb_we, wb_sel, wb_cti, wb_bte}, {1'b0, 4'hF, 3'b000, 2'b00});
    chk("dat_ms", wb_dat_ms, 32'h0);
  end

  // drive one cycle of inputs at the falling edge, then advance the model at the rising edge
  task automatic step(bit en, bit full, bit a, bit e, bit r, bit rs, logic [31:0] d);
    bit term;
    enable = en; af = full; ack = a; err = e; rty = r; rst = rs; dat_sm = d;
    @(posedge clk);
    if (rs) begin
      m_busy = 0; m_pos = 0; m_push = 0; m_sof = 0; m_wdata = 0;
    end else begin
      term = m_busy && (a || e);
      m_push = term;
      m_sof = term && m_pos == 0;
      if (term) begin
        m_wdata = a ? d : 32'h0;
        m_pos = (m_pos + 1) % NW;
      end
      m_busy = (m_busy && !term && !r) || ((!m_busy || term) && en && !full);
    end
    @(negedge clk);
  endtask

  initial begin
    @(negedge clk);
    run = 1;
    step(0, 0, 0, 0, 0, 1, 0);
    step(0, 0, 0, 0, 0, 1, 0);
    chk("rst_adr", wb_adr, 32'h0000_1000);
    chk("rst_cyc", wb_cyc, 0);
    chk("rst_wdata", fifo_wdata, 0);
    step(1, 0, 0, 0, 0, 0, 0);
    chk("rise", wb_cyc, 1);
    for (int i = 0; i < 9; i++) begin
      if (i == 1) chk("sof_first", fifo_sof, 1);
      if (i == 2) chk("sof_second", fifo_sof, 0);
      if (i == 3) chk("adr3", wb_adr, 32'h0000_100C);
      if (i == 7) chk("adr_last", wb_adr, 32'h0000_101C);
      if (i == 8) chk("wrap_adr", wb_adr, 32'h0000_1000);
      step(1, 0, wb_stb, 0, 0, 0, 32'hA000_0000 + i);
    end
    chk("wrap_write", fifo_write, 1);
    chk("wrap_sof", fifo_sof, 1);
    chk("wrap_data", fifo_wdata, 32'hA000_0008);
    for (int i = 0; i < 8; i++) step(1, 0, i % 2 == 1, 0, 0, 0, $urandom);
    step(1, 1, 1, 0, 0, 0, 32'h1234_5678);
    chk("af_push", fifo_write, 1);
    chk("af_drop", wb_cyc, 0);
    for (int i = 0; i < 3; i++) step(1, 1, 0, 0, 0, 0, 0);
    chk("af_hold", wb_cyc, 0);
    step(1, 0, 0, 0, 0, 0, 0);
    while (wb_adr != BASE + 12) step(1, 0, 1, 0, 0, 0, $urandom);
    step(1, 0, 0, 0, 1, 0, 0);
    chk("rty_nopush", fifo_write, 0);
    chk("rty_drop", wb_cyc, 0);
    step(1, 0, 0, 0, 0, 0, 0);
    chk("rty_reissue", wb_adr, BASE + 12);
    step(1, 0, 1, 0, 0, 0, 32'hCAFE_0003);
    step(1, 0, 0, 1, 0, 0, 32'hDEAD_BEEF);
    chk("err_zero", fifo_wdata, 0);
    chk("err_next", wb_adr, BASE + 20);
    step(0, 0, 0, 0, 0, 0, 0);
    chk("en_hold", wb_cyc, 1);
    step(0, 0, 1, 0, 0, 0, 32'h5555_AAAA);
    chk("en_push", fifo_wdata, 32'h5555_AAAA);
    chk("en_idle", wb_cyc, 0);
    step(1, 0, 0, 0, 0, 0, 0);
    chk("en_resume", wb_adr, BASE + 24);
    while (wb_adr != BASE + 20) step(1, 0, 1, 0, 0, 0, $urandom);
    step(1, 0, 1, 0, 0, 1, 32'h7777_7777);
    chk("rst_mid_cyc", wb_cyc, 0);
    chk("rst_mid_write", fifo_write, 0);
    chk("rst_mid_adr", wb_adr, BASE);
    for (int i = 0; i < 3000; i++) begin
      int r;
      r = $urandom_range(0, 19);
      step($urandom_range(0, 9) != 0, $urandom_range(0, 6) == 0,
           r < 8 || r == 18, r == 8 || r == 19, r == 9 || r == 18 || r == 19,
           $urandom_range(0, 149) == 0, $urandom);
    end
    run = 0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
